// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmit path. Host bytes are queued in a circular FIFO
// and sent as frames: start bit, data bits LSB first, optional even parity
// bit, one stop bit. The flag and BIST behaviour matches the receive FIFO.
//
// Ports:
//   Clk, Rst       clock and synchronous active-high reset
//   Tx_Data        byte to enqueue
//   Write_En       enqueue strobe, one word per cycle while high
//   BIST_Mode      while high, writes are ignored and never flag overflow
//   Tx_Serial      registered serial line, idles high
//   Tx_Busy        high while a frame is on the line
//   Tx_Done        one-cycle pulse after each stop bit
//   FIFO_Empty     FIFO holds no words (decoded from the registered count)
//   FIFO_Full      FIFO holds FIFO_DEPTH words (decoded from the registered count)
//   FIFO_Overflow  sticky: a write was dropped because the FIFO was full
module uart_tx_fifo #(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY_EN    = 1
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [DATA_BITS-1:0] Tx_Data,
    input  logic                 Write_En,
    input  logic                 BIST_Mode,
    output logic                 Tx_Serial,
    output logic                 Tx_Busy,
    output logic                 Tx_Done,
    output logic                 FIFO_Empty,
    output logic                 FIFO_Full,
    output logic                 FIFO_Overflow
);

    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam bit          HAS_PARITY = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t               state;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [BAUD_W-1:0]    baud_cnt;
    logic [BIT_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 parity_bit;

    logic                 baud_end;
    logic                 fifo_full;
    logic                 pop;
    logic                 push;
    logic                 write_req;
    logic [DATA_BITS-1:0] head;

    // Handshake decode between the FIFO and the serializer
    always_comb begin
        baud_end  = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
        fifo_full = (count == CNT_W'(FIFO_DEPTH));
        head      = mem[rd_ptr];
        // Pop from IDLE, or at the end of a stop bit so frames run back-to-back
        pop       = (count != CNT_W'(0)) &&
                    ((state == ST_IDLE) || ((state == ST_STOP) && baud_end));
        write_req = Write_En && !BIST_Mode;
        // A full FIFO still takes a word when a pop frees a slot in the same cycle
        push      = write_req && (!fifo_full || pop);
    end

    assign FIFO_Empty = (count == CNT_W'(0));
    assign FIFO_Full  = fifo_full;

    // FIFO storage; contents are don't-care once pointers and count reset
    always_ff @(posedge Clk) begin
        if (!Rst && push) begin
            mem[wr_ptr] <= Tx_Data;
        end
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            FIFO_Overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (write_req && !push) begin
                FIFO_Overflow <= 1'b1;
            end
        end
    end

    // Frame serializer with registered line, busy and done outputs
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= ST_IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            Tx_Serial  <= 1'b1;
            Tx_Busy    <= 1'b0;
            Tx_Done    <= 1'b0;
        end else begin
            Tx_Done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    baud_cnt <= '0;
                    if (pop) begin
                        shift_reg  <= head;
                        parity_bit <= ^head;
                        Tx_Serial  <= 1'b0;
                        Tx_Busy    <= 1'b1;
                        state      <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_end) begin
                        baud_cnt  <= '0;
                        bit_idx   <= '0;
                        Tx_Serial <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        state     <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == BIT_W'(DATA_BITS - 1)) begin
                            if (HAS_PARITY) begin
                                Tx_Serial <= parity_bit;
                                state     <= ST_PARITY;
                            end else begin
                                Tx_Serial <= 1'b1;
                                state     <= ST_STOP;
                            end
                        end else begin
                            bit_idx   <= bit_idx + BIT_W'(1);
                            Tx_Serial <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                ST_PARITY: begin
                    if (baud_end) begin
                        baud_cnt  <= '0;
                        Tx_Serial <= 1'b1;
                        state     <= ST_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                ST_STOP: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        Tx_Done  <= 1'b1;
                        if (pop) begin
                            // Next start bit follows the stop bit with no idle gap
                            shift_reg  <= head;
                            parity_bit <= ^head;
                            Tx_Serial  <= 1'b0;
                            state      <= ST_START;
                        end else begin
                            Tx_Serial <= 1'b1;
                            Tx_Busy   <= 1'b0;
                            state     <= ST_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                default: begin
                    baud_cnt  <= '0;
                    Tx_Serial <= 1'b1;
                    Tx_Busy   <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: drives a parity and a no-parity instance of uart_tx_fifo
// with shared stimulus and compares every cycle against a frame-level model
// (FIFO array plus "frame bits indexed by elapsed cycles / CLKS").
module tb_uart_tx_fifo;

    localparam int C = 4;
    localparam int D = 4;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic [7:0] Tx_Data = 8'h00;
    logic       Write_En = 1'b0;
    logic       BIST_Mode = 1'b0;

    logic [1:0] ser, busy, done, empty, full, ovf;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(D), .CLKS_PER_BIT(C), .PARITY_EN(1)) dut (
        .Clk(Clk), .Rst(Rst), .Tx_Data(Tx_Data), .Write_En(Write_En), .BIST_Mode(BIST_Mode),
        .Tx_Serial(ser[0]), .Tx_Busy(busy[0]), .Tx_Done(done[0]),
        .FIFO_Empty(empty[0]), .FIFO_Full(full[0]), .FIFO_Overflow(ovf[0])
    );

    uart_tx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(D), .CLKS_PER_BIT(C), .PARITY_EN(0)) dut_np (
        .Clk(Clk), .Rst(Rst), .Tx_Data(Tx_Data), .Write_En(Write_En), .BIST_Mode(BIST_Mode),
        .Tx_Serial(ser[1]), .Tx_Busy(busy[1]), .Tx_Done(done[1]),
        .FIFO_Empty(empty[1]), .FIFO_Full(full[1]), .FIFO_Overflow(ovf[1])
    );

    always #5 Clk = ~Clk;

    // Reference model state, index 0 = parity instance, 1 = no-parity instance
    logic [7:0]  mf [2][D];
    int          mh [2];
    int          ms [2];
    int          mt [2];
    int          nb [2];
    logic        act [2];
    logic        mdone [2];
    logic        movf [2];
    logic [10:0] fr [2];

    int bc [2];
    int dc [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input int m);
        int         pre;
        logic       pop;
        logic [7:0] w;
        if (Rst) begin
            mh[m] = 0; ms[m] = 0; mt[m] = 0; nb[m] = 10;
            act[m] = 1'b0; mdone[m] = 1'b0; movf[m] = 1'b0; fr[m] = '1;
            return;
        end
        mdone[m] = 1'b0;
        if (act[m]) begin
            mt[m]++;
            if (mt[m] == nb[m] * C) begin
                act[m]   = 1'b0;
                mdone[m] = 1'b1;
            end
        end
        pre = ms[m];
        pop = !act[m] && (pre > 0);
        if (pop) begin
            w     = mf[m][mh[m]];
            mh[m] = (mh[m] + 1) % D;
            ms[m]--;
            act[m] = 1'b1;
            mt[m]  = 0;
            if (m == 0) begin
                fr[m] = {1'b1, ^w, w, 1'b0};
                nb[m] = 11;
            end else begin
                fr[m] = {2'b11, w, 1'b0};
                nb[m] = 10;
            end
        end
        if (Write_En && !BIST_Mode) begin
            if (pre < D || pop) begin
                mf[m][(mh[m] + ms[m]) % D] = Tx_Data;
                ms[m]++;
            end else begin
                movf[m] = 1'b1;
            end
        end
    endtask

    always @(posedge Clk) begin
        model_step(0);
        model_step(1);
    end

    // Per-cycle comparison of every output of both instances
    always @(negedge Clk) begin
        for (int m = 0; m < 2; m++) begin
            logic exp_ser;
            exp_ser = act[m] ? fr[m][mt[m] / C] : 1'b1;
            check($sformatf("serial%0d", m), 32'(ser[m]),   32'(exp_ser));
            check($sformatf("busy%0d", m),   32'(busy[m]),  32'(act[m]));
            check($sformatf("done%0d", m),   32'(done[m]),  32'(mdone[m]));
            check($sformatf("empty%0d", m),  32'(empty[m]), 32'(ms[m] == 0));
            check($sformatf("full%0d", m),   32'(full[m]),  32'(ms[m] == D));
            check($sformatf("ovf%0d", m),    32'(ovf[m]),   32'(movf[m]));
            bc[m] += 32'(busy[m]);
            dc[m] += 32'(done[m]);
        end
    end

    task automatic do_reset();
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d);
        Tx_Data  = d;
        Write_En = 1'b1;
        @(negedge Clk);
        Write_En = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((busy != 2'b00 || empty != 2'b11) && n < 3000) begin
            @(negedge Clk);
            n++;
        end
        check("drain_timeout", 32'(n < 3000), 32'd1);
        repeat (2) @(negedge Clk);
    endtask

    initial begin
        int b0, b1, d0, d1, n;
        bc[0] = 0; bc[1] = 0; dc[0] = 0; dc[1] = 0;
        Rst = 1'b1;
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);

        // Single byte 0xA5: 44-cycle parity frame, 40-cycle plain frame
        b0 = bc[0]; b1 = bc[1]; d0 = dc[0]; d1 = dc[1];
        write_byte(8'hA5);
        wait_drain();
        check("a5_len_p",  32'(bc[0] - b0), 32'd44);
        check("a5_len_np", 32'(bc[1] - b1), 32'd40);
        check("a5_done_p", 32'(dc[0] - d0), 32'd1);
        check("a5_done_np", 32'(dc[1] - d1), 32'd1);

        // Single byte 0x07
        b0 = bc[0]; b1 = bc[1];
        write_byte(8'h07);
        wait_drain();
        check("07_len_p",  32'(bc[0] - b0), 32'd44);
        check("07_len_np", 32'(bc[1] - b1), 32'd40);

        // Overflow: six consecutive writes, the sixth is dropped
        b0 = bc[0]; b1 = bc[1]; d0 = dc[0]; d1 = dc[1];
        for (int i = 1; i <= 6; i++) begin
            Tx_Data  = 8'(i);
            Write_En = 1'b1;
            @(negedge Clk);
            if (i == 5) check("full_after_5", 32'(full[0]), 32'd1);
        end
        Write_En = 1'b0;
        check("ovf_set", 32'(ovf[0]), 32'd1);
        wait_drain();
        check("ovf_len_p",   32'(bc[0] - b0), 32'd220);
        check("ovf_len_np",  32'(bc[1] - b1), 32'd200);
        check("ovf_done_p",  32'(dc[0] - d0), 32'd5);
        check("ovf_done_np", 32'(dc[1] - d1), 32'd5);
        check("ovf_sticky",  32'(ovf[0]), 32'd1);
        do_reset();
        check("ovf_cleared", 32'(ovf[0]), 32'd0);

        // BIST blocks writes
        BIST_Mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            write_byte(8'h33);
            @(negedge Clk);
        end
        BIST_Mode = 1'b0;
        check("bist_empty", 32'(empty), 32'd3);
        check("bist_ovf",   32'(ovf),   32'd0);
        check("bist_line",  32'(ser),   32'd3);

        // Push on the pop cycle at the end of STOP while full
        d0 = dc[0];
        for (int i = 0; i < 5; i++) begin
            Tx_Data  = 8'h10 + 8'(i);
            Write_En = 1'b1;
            @(negedge Clk);
        end
        Write_En = 1'b0;
        n = 0;
        while (!(act[0] && mt[0] == nb[0] * C - 1) && n < 100) begin
            @(negedge Clk);
            n++;
        end
        check("stop_wait_timeout", 32'(n < 100), 32'd1);
        check("full_before_pop", 32'(full[0]), 32'd1);
        write_byte(8'hC3);
        check("full_after_pushpop", 32'(full[0]), 32'd1);
        check("no_ovf_pushpop",     32'(ovf[0]),  32'd0);
        wait_drain();
        check("pushpop_done_p", 32'(dc[0] - d0), 32'd6);
        do_reset();

        // Reset during data bit 3 of 0xFF
        d0 = dc[0];
        write_byte(8'hFF);
        n = 0;
        while (!(act[0] && mt[0] / C == 4) && n < 100) begin
            @(negedge Clk);
            n++;
        end
        check("bit3_wait_timeout", 32'(n < 100), 32'd1);
        do_reset();
        check("rst_line",  32'(ser[0]),   32'd1);
        check("rst_busy",  32'(busy[0]),  32'd0);
        check("rst_empty", 32'(empty[0]), 32'd1);
        repeat (60) @(negedge Clk);
        check("rst_no_done", 32'(dc[0] - d0), 32'd0);

        // Randomized traffic with varying write density
        for (int blk = 0; blk < 20; blk++) begin
            int dens;
            dens = $urandom_range(1, 40);
            for (int i = 0; i < 200; i++) begin
                Write_En  = ($urandom_range(0, dens - 1) == 0);
                BIST_Mode = ($urandom_range(0, 7) == 0);
                Tx_Data   = 8'($urandom);
                Rst       = ($urandom_range(0, 999) == 0);
                @(negedge Clk);
            end
        end
        Write_En = 1'b0; BIST_Mode = 1'b0; Rst = 1'b0;
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
